// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so consecutive
// frames leave back-to-back; tx idles high and data goes out LSB first.
module uart_tx #(
  parameter int CLOCK_DIVIDE  = 5,
  parameter int TICKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_ready,
  output logic       is_transmitting
);

  localparam int DW = (CLOCK_DIVIDE  > 1) ? $clog2(CLOCK_DIVIDE)  : 1;
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shifter;
  logic [7:0]    hold;
  logic          hold_full;

  logic       div_last, tick_last, bit_end, stop_last, accept;
  logic       load, clear_hold;
  logic [7:0] load_byte;

  assign div_last  = (div_cnt  == DW'(CLOCK_DIVIDE  - 1));
  assign tick_last = (tick_cnt == TW'(TICKS_PER_BIT - 1));
  assign bit_end   = div_last && tick_last;
  assign stop_last = (state == STOP) && bit_end;
  assign tx_ready  = !hold_full && !rst;
  assign accept    = transmit && tx_ready;

  // A new frame can only begin from IDLE or on the final stop cycle; a pending
  // held byte takes priority, otherwise an accept on that cycle bypasses hold.
  always_comb begin
    load       = 1'b0;
    clear_hold = 1'b0;
    load_byte  = hold;
    if (state == IDLE || stop_last) begin
      if (hold_full) begin
        load       = 1'b1;
        clear_hold = 1'b1;
      end else if (accept) begin
        load      = 1'b1;
        load_byte = tx_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      hold_full       <= 1'b0;
      hold            <= '0;
      shifter         <= '0;
      div_cnt         <= '0;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
    end else begin
      if (clear_hold)
        hold_full <= 1'b0;
      else if (accept && !load) begin
        hold      <= tx_byte;
        hold_full <= 1'b1;
      end

      // Bit timing restarts on every frame load, so edges stay frame-aligned.
      if (state != IDLE) begin
        if (div_last) begin
          div_cnt  <= '0;
          tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
        end else
          div_cnt <= div_cnt + 1'b1;
      end

      if (load) begin
        state           <= START;
        tx              <= 1'b0;
        shifter         <= load_byte;
        bit_cnt         <= 4'd8;
        div_cnt         <= '0;
        tick_cnt        <= '0;
        is_transmitting <= 1'b1;
      end else if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            tx    <= shifter[0];
          end
          DATA: begin
            if (bit_cnt == 4'd1) begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_cnt <= '0;
            end else begin
              tx      <= shifter[1];
              shifter <= shifter >> 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          STOP: begin
            state           <= IDLE;
            is_transmitting <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus random traffic, checked each
// cycle against a frame-level timing model and an independent line decoder.
module tb_uart_tx;

  localparam int BIT   = 20;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       tx, tx_ready, is_transmitting;

  uart_tx #(.CLOCK_DIVIDE(5), .TICKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
    .tx(tx), .tx_ready(tx_ready), .is_transmitting(is_transmitting)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s @cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Reference model: the line is described by the start cycle and byte of the
  // frame in flight plus an optional held byte.
  bit         busy = 0;
  int         fstart = 0;
  logic [7:0] fbyte = '0;
  bit         hv = 0;
  logic [7:0] hb = '0;
  int         n_done = 0;
  logic [7:0] frames_q[$];

  function automatic logic exp_tx();
    int k;
    if (!busy) return 1'b1;
    k = (cyc - fstart) / BIT;
    if (k == 0) return 1'b0;
    if (k <= 8) return fbyte[k-1];
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] b);
    busy   = 1;
    fstart = cyc + 1;
    fbyte  = b;
    frames_q.push_back(b);
  endtask

  task automatic model_step(input logic r, input logic t, input logic [7:0] b);
    bit acc, last;
    if (r) begin
      busy = 0;
      hv   = 0;
      frames_q.delete();
      return;
    end
    acc  = t && !hv;
    last = busy && (cyc - fstart == FRAME - 1);
    if (last) n_done++;
    if (!busy || last) begin
      if (hv) begin
        hv = 0;
        start_frame(hb);
      end else if (acc)
        start_frame(b);
      else
        busy = 0;
    end else if (acc) begin
      hv = 1;
      hb = b;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
  task automatic step(input logic r, input logic t, input logic [7:0] b);
    rst = r; transmit = t; tx_byte = b;
    @(negedge clk);
    chk("tx", tx, exp_tx());
    chk("tx_ready", tx_ready, !hv && !r);
    chk("is_transmitting", is_transmitting, busy);
    model_step(r, t, b);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    for (int i = 0; i < 2 * FRAME && hv; i++) step(0, 0, 8'h00);
    step(0, 1, b);
  endtask

  // Independent decoder: samples the line at mid-bit and checks each byte.
  bit         dbusy = 0;
  int         dcnt = 0;
  int         n_rx = 0;
  logic [7:0] dbyte = '0;
  always @(negedge clk) begin
    if (rst) dbusy = 0;
    else if (!dbusy) begin
      if (tx === 1'b0) begin dbusy = 1; dcnt = 0; end
    end else begin
      dcnt++;
      if (dcnt % BIT == BIT / 2) begin
        if (dcnt / BIT >= 1 && dcnt / BIT <= 8) dbyte[dcnt/BIT-1] = tx;
        if (dcnt / BIT == 9) begin
          chk("rx_stop_bit", tx, 1'b1);
          chk("rx_byte", dbyte, frames_q.size() > 0 ? frames_q.pop_front() : 8'hxx);
          n_rx++;
          dbusy = 0;
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    step(1, 0, 8'h00);
    step(1, 1, 8'hAA);
    idle(5);

    // single byte from idle
    send(8'h55);
    idle(FRAME + 10);

    // two bytes, the second held; 0xFF offered while hold is full
    send(8'hA5);
    idle(1);
    send(8'h3C);
    idle(2);
    step(0, 1, 8'hFF);
    idle(2 * FRAME + 10);

    // reset mid-frame with a held byte
    send(8'h0F);
    send(8'hF0);
    while (cyc - fstart < 5 * BIT + 3) step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    idle(FRAME + 50);

    // back-to-back stream
    send(8'h00);
    send(8'hFF);
    send(8'h81);
    send(8'h7E);
    idle(2 * FRAME + 10);

    // accept on the exact last stop cycle with hold empty
    send(8'h12);
    while (cyc - fstart < FRAME - 1) step(0, 0, 8'h00);
    step(0, 1, 8'h34);
    idle(FRAME + 10);

    // random traffic with occasional resets
    for (int i = 0; i < 5000; i++)
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 39) == 0, 8'($urandom));
    idle(2 * FRAME + 10);

    chk("rx_count", n_rx, n_done);
    chk("frames_pending", frames_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter, the companion of the `uart` receive block, using the same clock and baud assumptions (6 kHz clk, 300 baud, 20 clk per bit).
- Accepts bytes from core logic through a one-entry holding register, so back-to-back frames go out with no idle gap.
- Drives the serial `tx` line: idle high, LSB first.

Parameters:
- CLOCK_DIVIDE, 5: clk cycles per sub-bit tick.
- TICKS_PER_BIT, 4: ticks per bit period. Bit period = CLOCK_DIVIDE*TICKS_PER_BIT clk (default 20).

Ports:
- clk  input  1  master clock.
- rst  input  1  synchronous reset, active-high.
- transmit  input  1  byte-valid strobe; byte accepted on a cycle with transmit && tx_ready.
- tx_byte  input  8  data byte, sampled on the accept cycle.
- tx  output  1  serial line.
- tx_ready  output  1  holding register empty and rst low; combinational.
- is_transmitting  output  1  high while a frame is on the line (state != IDLE); registered.

Behaviour:
- Reset (rst high at a clk edge):
  - State -> IDLE, tx=1, hold_full=0, shifter, divider and bit counters cleared.
  - Applies mid-frame too: tx returns high on the next cycle, the frame is truncated, and any held byte is discarded.
  - transmit is ignored while rst is high; tx_ready=0 while rst is high.
- Accept:
  - On cycle N with transmit && tx_ready, the byte either goes to the holding register or, on the bypass path below, straight into the shifter.
  - Bypass applies when state==IDLE, or when cycle N is the final cycle of a STOP bit. The byte loads the shifter directly and the start bit begins at N+1 (tx low at N+1). hold_full stays 0.
  - Otherwise: hold <= tx_byte, hold_full <= 1 at N+1.
- States:
  - IDLE: tx=1. If hold_full, load hold into shifter, clear hold_full, go to START (tx low next cycle).
  - START: tx=0 for exactly one bit period, then DATA.
  - DATA: tx = shifter[0], each bit held one bit period, shift right. Bit counter runs 8 -> 0; after the 8th bit, go to STOP.
  - STOP: tx=1 for one bit period. On its last cycle:
    - If hold_full, go to START and clear hold_full.
    - Else if a bypass accept occurs, go to START.
    - Else go to IDLE.
- Timing:
  - Divider and tick counter restart at every START entry, so bit edges are frame-aligned, not free-running.
  - Every bit lasts exactly CLOCK_DIVIDE*TICKS_PER_BIT cycles. A frame is 10 bit periods (200 clk default).
  - Back-to-back: the next start bit immediately follows the stop bit, with zero extra cycles.
- Holding register:
  - While full, tx_ready=0; transmit is ignored and tx_byte is not sampled.
  - tx_ready returns high the cycle after the hold moves into the shifter.
  - At most one byte is in the shifter plus one in hold.
- is_transmitting:
  - Rises the same cycle tx first goes low.
  - Falls the cycle tx enters IDLE after a stop bit with no pending byte.
- Counter widths:
  - Sized by $clog2 of the parameters.
  - Counters never wrap past the terminal count; they reload.

Test Plan:
- Reset, then transmit 0x55 at cycle N with the block idle:
  - tx low at N+1..N+20.
  - Data bits 1,0,1,0,1,0,1,0 at 20 clk each.
  - Stop high N+181..N+200.
  - is_transmitting falls at N+201.
- Send 0xA5, then 0x3C two cycles later:
  - tx_ready drops after the second accept.
  - The second start bit begins exactly 200 clk after the first.
  - tx_ready rises one cycle after the 0x3C load.
- While hold is full, pulse transmit with 0xFF:
  - The byte is ignored.
  - Only the two earlier frames appear on tx.
- Assert rst at the 5th data bit of 0x0F with 0xF0 held:
  - tx=1 the next cycle.
  - hold_full=0, tx_ready=1 after rst deasserts.
  - No further frames.
- Loopback tx into the `uart` receive block (CLOCK_DIVIDE=5), sending 0x00, 0xFF, 0x81, 0x7E back-to-back:
  - One received pulse per byte.
  - rx_byte matches each byte.
  - No RX_ERROR.
- Assert transmit on the exact last STOP cycle with hold empty:
  - Bypass: the new start bit begins the next cycle.
  - hold_full stays 0.
